// File: rtl/corner_scan_ctrl.sv
// corner_scan_ctrl: walks the 24 corner facelets through the index table and packs
// the 3-bit colour codes read from a start-time snapshot of the cube state.
module corner_scan_ctrl #(
  parameter int STATE_W = 162
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [STATE_W-1:0] cubestate,
  output logic [4:0]         corner_num,
  input  logic [7:0]         ind,
  output logic               busy,
  output logic               done,
  output logic               corners_valid,
  output logic [71:0]        corners,
  output logic               range_err
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  state_t             r_state, w_state;
  logic [4:0]         r_cnt, w_cnt;
  logic               r_t1_v, r_t2_v, w_t1_v;
  logic [4:0]         r_t1_id, r_t2_id, w_t1_id;
  logic [STATE_W-1:0] r_snap;
  logic [71:0]        r_corners;
  logic               r_done, r_valid, r_err;
  logic               w_flush, w_start, w_cap, w_last, w_oor;
  logic [2:0]         w_code;
  assign w_flush = abort && (r_state != IDLE);
  assign w_cap   = r_t2_v && !w_flush;
  assign w_last  = w_cap && (r_t2_id == 5'd23);
  // ind is 8 bits wide, so offsets past the snapshot are caught here rather than wrapped
  assign w_oor   = (int'(ind) + 2) >= STATE_W;
  assign w_code  = 3'(r_snap >> ind);
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_t1_v  = 1'b0;
    w_t1_id = 5'd0;
    w_start = 1'b0;
    if (w_flush) begin
      w_state = IDLE;
      w_cnt   = 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          w_start = start;
          w_t1_v  = start;
          w_state = start ? SCAN : IDLE;
        end
        SCAN: begin
          w_cnt   = r_cnt + 5'd1;
          w_t1_v  = 1'b1;
          w_t1_id = r_cnt + 5'd1;
          w_state = (r_cnt == 5'd22) ? DRAIN : SCAN;
        end
        DRAIN: begin
          w_state = w_last ? IDLE : DRAIN;
          w_cnt   = w_last ? 5'd0 : r_cnt;
        end
        default: w_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
    end
  end
  // tags follow each issued index through the table's one-cycle latency
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_t1_v    <= 1'b0;
      r_t1_id   <= 5'd0;
      r_t2_v    <= 1'b0;
      r_t2_id   <= 5'd0;
      r_snap    <= '0;
      r_corners <= '0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_t1_v  <= w_t1_v;
      r_t1_id <= w_t1_id;
      r_t2_v  <= r_t1_v && !w_flush;
      r_t2_id <= r_t1_id;
      r_done  <= w_last;
      if (w_start) begin
        r_snap  <= cubestate;
        r_valid <= 1'b0;
        r_err   <= 1'b0;
      end
      if (w_cap) begin
        r_corners[7'(69 - 3 * int'(r_t2_id)) +: 3] <= w_oor ? 3'b000 : w_code;
        if (w_oor) r_err <= 1'b1;
      end
      if (w_last) r_valid <= 1'b1;
    end
  end
  assign corner_num    = r_cnt;
  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign corners_valid = r_valid;
  assign corners       = r_corners;
  assign range_err     = r_err;
endmodule

// File: tb/tb_corner_scan_ctrl.sv
// tb_corner_scan_ctrl: directed scan vectors against a registered index-table model
// (ind = 3k+75, optionally 160 for one poisoned corner).
module tb_corner_scan_ctrl;
  typedef struct {
    logic [161:0] cs;
    int           bad_k;
    int           abort_at;
    int           invert_at;
  } vec_t;
  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [161:0] cubestate = '0;
  logic [4:0]   corner_num;
  logic [7:0]   ind;
  logic         busy, done, corners_valid, range_err;
  logic [71:0]  corners;
  int           bad_k = -1;
  int           n_vec = 0;
  int           n_bad = 0;
  logic [2:0]   exp_c [24];
  vec_t         vecs [5];
  corner_scan_ctrl #(.STATE_W(162)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .cubestate(cubestate), .corner_num(corner_num), .ind(ind), .busy(busy),
    .done(done), .corners_valid(corners_valid), .corners(corners), .range_err(range_err)
  );
  always #5 clock = ~clock;
  always @(posedge clock) ind <= (int'(corner_num) == bad_k) ? 8'd160 : 8'(3 * int'(corner_num) + 75);
  function automatic logic [161:0] rand162();
    logic [161:0] v = '0;
    for (int i = 0; i < 6; i++) v = (v << 32) | 162'($urandom());
    return v;
  endfunction
  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic run(input int idx, input vec_t v);
    logic [71:0] exp_vec;
    logic        alive;
    logic [4:0]  exp_cn;
    logic        exp_err;
    cubestate = v.cs;
    bad_k     = v.bad_k;
    start     = 1'b1;
    for (int k = 0; k < 24; k++)
      if (v.abort_at < 0 || k + 2 < v.abort_at)
        exp_c[k] = (k == v.bad_k) ? 3'b000 : v.cs[3 * k + 75 +: 3];
    for (int e = 0; e <= 26; e++) begin
      @(posedge clock);
      #1;
      start = 1'b0;
      if (e == v.invert_at) cubestate = ~cubestate;
      abort   = (v.abort_at >= 0 && e + 1 == v.abort_at);
      alive   = (v.abort_at < 0 || e < v.abort_at);
      exp_cn  = (!alive || e >= 25) ? 5'd0 : (e > 23 ? 5'd23 : 5'(e));
      exp_err = v.bad_k >= 0 && e >= v.bad_k + 2 && (v.abort_at < 0 || v.bad_k + 2 < v.abort_at);
      chk($sformatf("v%0d cyc%0d busy/done/err/valid/cn", idx, e),
          72'({busy, done, range_err, corners_valid, corner_num}),
          72'({alive && e < 25, v.abort_at < 0 && e == 25, exp_err, v.abort_at < 0 && e >= 25, exp_cn}));
    end
    abort = 1'b0;
    for (int k = 0; k < 24; k++) exp_vec[71 - 3 * k -: 3] = exp_c[k];
    chk($sformatf("v%0d corners", idx), corners, exp_vec);
  endtask
  initial begin
    int d0, d1, d2, nd;
    vecs[0] = '{rand162(), -1, -1, -1};
    vecs[1] = '{rand162(), -1, -1,  3};
    vecs[2] = '{rand162(),  7, -1, -1};
    vecs[3] = '{rand162(), -1, 10, -1};
    vecs[4] = '{rand162(), -1, -1, -1};
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("reset outputs", 72'({busy, done, range_err, corners_valid, corner_num}), 72'd0);
    chk("reset corners", corners, 72'd0);
    for (int i = 0; i < 5; i++) run(i, vecs[i]);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midscan reset outputs", 72'({busy, done, range_err, corners_valid, corner_num}), 72'd0);
    chk("midscan reset corners", corners, 72'd0);
    @(negedge clock) reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("post reset idle", 72'({busy, corner_num}), 72'd0);
    cubestate = rand162();
    bad_k = -1;
    start = 1'b1;
    d0 = -1; d1 = -1; d2 = -1; nd = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clock);
      #1;
      if (c == 26) chk("held start reaccept busy", 72'(busy), 72'd1);
      if (done) begin
        if (nd == 0) d0 = c;
        if (nd == 1) d1 = c;
        if (nd == 2) d2 = c;
        nd++;
      end
    end
    start = 1'b0;
    chk("held start done count", 72'(nd), 72'd3);
    chk("held start first done", 72'(d0), 72'd25);
    chk("held start period 1", 72'(d1 - d0), 72'd26);
    chk("held start period 2", 72'(d2 - d1), 72'd26);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/corner_scan_ctrl.md
# corner_scan_ctrl

Sequencer that walks the 24 corner facelets of the cube in learning order (0..23), drives the corner-index table with `corner_num`, and uses each returned bit offset `ind` to pull a 3-bit colour code out of a snapshot of `cubestate`. The 24 codes are packed into a 72-bit corner vector for the solver. The block sits between the cube-state register and the solver and owns the corner-index table's `corner_num` input.

## Interface
- `STATE_W`, 162: width of `cubestate` (54 stickers × 3 bits).
- `clock`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a scan; sampled only in IDLE.
- `abort`  in  1: cancel an in-progress scan.
- `cubestate`  in  STATE_W: live cube state; snapshotted on start.
- `corner_num`  out  5: index presented to the corner-index table.
- `ind`  in  8: bit offset from the table; registered, valid 1 cycle after `corner_num`.
- `busy`  out  1: scan in progress.
- `done`  out  1: one-cycle pulse when all 24 corners have been captured.
- `corners_valid`  out  1: `corners` is complete and coherent.
- `corners`  out  72: corner k at bits [71-3k : 69-3k].
- `range_err`  out  1: sticky; some `ind`+2 ≥ STATE_W during this scan.

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE:
  - `corner_num`=0.
  - On `start`=1: snapshot `cubestate` into `snap`, set issue_cnt=0, clear `range_err` and `corners_valid`, go to SCAN.
  - `corners` is not cleared.
- SCAN:
  - `corner_num`=issue_cnt; issue_cnt increments every cycle.
  - Issuing continues up to 23, then go to DRAIN.
- Capture pipeline:
  - A 2-stage tag shift register (valid bit + 5-bit corner id) tracks each issued index through the table's 1-cycle latency.
  - When the tag at stage 2 is valid, write `snap[ind +: 3]` into the slot for that corner id.
  - If `ind`+2 ≥ STATE_W: write 3'b000 instead and set `range_err`.
- DRAIN:
  - `corner_num` holds 23.
  - When the capture for corner 23 completes: pulse `done`, set `corners_valid`, go to IDLE.
- `start` while not in IDLE is ignored; no queueing.
- `abort`=1 in SCAN or DRAIN:
  - Next state is IDLE and the tag pipeline is flushed.
  - No further captures; `done` does not pulse; `corners_valid` stays 0.
  - Partially written `corners` is retained.
- `abort` in IDLE has no effect. `abort` and `start` together in IDLE: `start` wins.
- Changes to `cubestate` after the start edge have no effect on the current scan.
- `ind` values ≥ 128 are handled by the range check; no wrap-around.

## Timing
- Reset values:
  - `corner_num`=0, `busy`=0, `done`=0, `corners_valid`=0, `corners`=0, `range_err`=0.
  - State IDLE, pipeline tags invalid.
  - Reset mid-scan behaves identically to power-on reset.
- Let E0 be the edge sampling `start`=1.
  - After E0: `busy`=1 and `corner_num`=0.
  - After Ek (k=0..23): `corner_num`=k.
  - The table registers `corner_num`=k at E(k+1); the block captures corner k at E(k+2).
  - Last capture is at E25. After E25: `done`=1 for exactly one cycle, `corners_valid`=1, `busy`=0.
  - Start-to-done latency: 25 cycles.
- Back-to-back scans:
  - A `start` sampled at E26, the cycle `done` is high, is accepted.
  - Minimum period between accepted starts is 26 cycles.
- `abort` sampled at edge Ea: after Ea, `busy`=0, `corner_num`=0, and no capture occurs at Ea or later.
- `range_err` updates at the capture edge of the offending corner and holds until the next accepted `start`.

## Test plan
- Reset then idle:
  - Stimulus: hold `reset_n`=0, release, wait 5 cycles.
  - Required: all outputs 0, `corner_num`=0.
- Full scan with a table model giving ind=3k+75 and `cubestate` sticker fields set to distinct patterns.
  - Required: `corner_num` sequence 0..23 on consecutive cycles.
  - Required: `done` pulses exactly 25 cycles after start.
  - Required: corner k holds `cubestate`[3k+77:3k+75].
  - Required: `range_err`=0.
- Snapshot isolation:
  - Stimulus: invert `cubestate` 3 cycles after start.
  - Required: `corners` matches the pre-start snapshot.
- Range check:
  - Stimulus: table returns ind=160 for corner 7.
  - Required: corner 7 reads 3'b000, `range_err`=1 from the E9 capture through `done`; the other 23 corners are correct.
- Abort:
  - Stimulus: `abort` at E10.
  - Required: `busy`=0 after E10, no `done`, `corners_valid`=0.
  - Required: corners 0..7 written, corners 8..23 unchanged from the prior scan.
- Start handling:
  - Stimulus: `start` held high throughout.
  - Required: `start` pulses during the scan are ignored; scans occur back-to-back with 26-cycle period, `done` pulses every 26 cycles.
